debug_cmd_sysclk_bridge: RTL and testbench
==========================================

Name: debug_cmd_sysclk_bridge

Overview:
Parametrised system-clock-side receiver for the CPU JTAG debug path. It synchronises update-DR/update-IR strobes arriving from the TCK domain and captures the shift register into a command. Commands are queued in a small FIFO and decoded into per-instruction take_action/take_no_action pulses. It generalises the fixed 38-bit/2-bit-IR sysclk block with configurable widths, sync depth, command buffering and overflow reporting.

Parameters:
SR_WIDTH, 38, width of captured shift register / jdo
IR_WIDTH, 2, virtual-JTAG instruction width; 2**IR_WIDTH action channels
SYNC_STAGES, 2, synchroniser depth for vs_udr/vs_uir (min 2)
FIFO_DEPTH, 4, command queue depth (power of 2, min 2)
ACTION_BIT, 35, bit of captured sr that selects take_action (1) vs take_no_action (0)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sr  in  SR_WIDTH  TCK-domain shift register; held stable by the TCK side while vs_udr is high
ir_in  in  IR_WIDTH  TCK-domain instruction register; stable while vs_udr is high
vs_udr  in  1  TCK-domain update-DR level (async)
vs_uir  in  1  TCK-domain update-IR level (async)
cmd_ready  in  1  consumer accepts head command
clear_overflow  in  1  clears overflow sticky flag
cmd_valid  out  1  FIFO non-empty
cmd_ir  out  IR_WIDTH  instruction of head command
jdo  out  SR_WIDTH  data of head command
take_action  out  2**IR_WIDTH  one-hot, one-cycle pulse per accepted command with ACTION_BIT=1
take_no_action  out  2**IR_WIDTH  one-hot, one-cycle pulse per accepted command with ACTION_BIT=0
ir_update  out  1  one-cycle pulse on synchronised vs_uir rising edge
overflow  out  1  sticky: command dropped because the FIFO was full
fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (async assert, sync release): sync chains 0, FIFO empty, all outputs 0, fifo_level 0, overflow 0. Reset mid-operation discards queued commands.
- Post-reset mask: a counter blocks edge detection for SYNC_STAGES+1 cycles after reset release. A strobe already high at release produces no event until it falls and rises again.
- Sync: vs_udr/vs_uir each pass through SYNC_STAGES flops. Edge = last stage & ~previous-cycle last stage.
- udr edge: push {ir_in, sr} into FIFO in that cycle. sr/ir_in are sampled directly as multi-bit, which is legal because they are stable under vs_udr.
- Latency: vs_udr high at clk edge 0 -> cmd_valid high after edge SYNC_STAGES+1 (3 cycles by default).
- Push rule: accepted if not full, or if full and a pop occurs in the same cycle. Otherwise the command is dropped, overflow is set, and fifo_level is unchanged.
- Pop: cmd_valid & cmd_ready. FIFO is first-word-fall-through; cmd_ir/jdo show the head and hold their value when the FIFO is empty.
- Decode (registered, 1 cycle after pop):
  - take_action[cmd_ir]=1 if jdo[ACTION_BIT]=1, else take_no_action[cmd_ir]=1.
  - The other bits are 0. At most one bit across both vectors is high per cycle.
- Push and pop in the same cycle: level unchanged. On an empty FIFO the pushed entry is not popped that cycle, because cmd_valid was 0.
- ir_update pulses on the synchronised vs_uir edge and does not affect the FIFO.
- Overflow: clear_overflow clears it. If a drop and clear_overflow occur in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.

Test Plan:
- Reset, then vs_udr pulse (4 clk) with ir_in=2, sr=38'h08_1234_5678, cmd_ready=1 -> cmd_valid at cycle 3, jdo=38'h08_1234_5678; next cycle take_action=4'b0100, take_no_action=0.
- sr[35]=0, ir_in=1, one udr pulse -> take_no_action=4'b0010 for exactly one cycle; take_action stays 0.
- cmd_ready=0, five udr pulses -> fifo_level=4 and overflow=1; data pops in order 1..4 and the fifth is lost. clear_overflow -> overflow=0.
- FIFO full, udr edge coincident with a pop -> no overflow, fifo_level stays 4, new entry is at the tail.
- vs_udr held high across reset release -> no command. Drop it, then raise it again -> exactly one command.
- Assert reset while 3 entries are queued -> cmd_valid=0, fifo_level=0, all pulse outputs 0 immediately (async).

Source files
------------

// File: rtl/debug_cmd_sysclk_bridge.sv
// System-clock side of the JTAG debug path: synchronises TCK-domain update strobes, queues
// captured {ir, sr} commands in a FWFT FIFO and decodes popped commands into action pulses.
module debug_cmd_sysclk_bridge #(
   parameter int unsigned SR_WIDTH    = 38,
   parameter int unsigned IR_WIDTH    = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned ACTION_BIT  = 35
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [SR_WIDTH-1:0]           sr,
   input  logic [IR_WIDTH-1:0]           ir_in,
   input  logic                          vs_udr,
   input  logic                          vs_uir,
   input  logic                          cmd_ready,
   input  logic                          clear_overflow,
   output logic                          cmd_valid,
   output logic [IR_WIDTH-1:0]           cmd_ir,
   output logic [SR_WIDTH-1:0]           jdo,
   output logic [(2**IR_WIDTH)-1:0]      take_action,
   output logic [(2**IR_WIDTH)-1:0]      take_no_action,
   output logic                          ir_update,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned NumChan = 2**IR_WIDTH;
   localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW    = PtrW + 1;
   localparam int unsigned EntW    = IR_WIDTH + SR_WIDTH;
   localparam int unsigned MaskW   = $clog2(SYNC_STAGES + 2);
   localparam logic [MaskW-1:0] MaskEnd = MaskW'(SYNC_STAGES + 1);

   // ---------------------------------------------------------------------------------------
   // Strobe synchronisers, post-reset mask and registered edge detect
   // ---------------------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
   logic                   udr_prev_q, uir_prev_q;
   logic                   udr_rise_q, uir_rise_q;
   logic [MaskW-1:0]       mask_cnt_q;
   logic                   udr_last, uir_last;
   logic                   edge_en;

   assign udr_last = udr_sync_q[SYNC_STAGES-1];
   assign uir_last = uir_sync_q[SYNC_STAGES-1];
   // A strobe already high at release fills the chain while still masked, so it never edges.
   assign edge_en  = (mask_cnt_q == MaskEnd);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         udr_sync_q <= '0;
         uir_sync_q <= '0;
         udr_prev_q <= 1'b0;
         uir_prev_q <= 1'b0;
         udr_rise_q <= 1'b0;
         uir_rise_q <= 1'b0;
         mask_cnt_q <= '0;
      end else begin
         udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
         uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
         udr_prev_q <= udr_last;
         uir_prev_q <= uir_last;
         udr_rise_q <= udr_last & ~udr_prev_q & edge_en;
         uir_rise_q <= uir_last & ~uir_prev_q & edge_en;
         if (!edge_en) begin
            mask_cnt_q <= mask_cnt_q + MaskW'(1);
         end
      end
   end

   assign ir_update = uir_rise_q;

   // ---------------------------------------------------------------------------------------
   // Command FIFO
   // ---------------------------------------------------------------------------------------
   logic [EntW-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic [EntW-1:0] hold_q;
   logic [EntW-1:0] head;
   logic            full;
   logic            push_req, push_ok, pop, drop;

   assign head      = mem_q[rd_ptr_q];
   assign cmd_valid = (count_q != '0);
   assign full      = (count_q == CntW'(FIFO_DEPTH));
   assign push_req  = udr_rise_q;
   assign pop       = cmd_valid & cmd_ready;
   // A pop in the same cycle frees the slot the new entry needs.
   assign push_ok   = push_req & (~full | pop);
   assign drop      = push_req & full & ~pop;

   always_comb begin
      count_d = count_q;
      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hold_q   <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= {ir_in, sr};
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         if (cmd_valid) begin
            hold_q <= head;
         end
         count_q <= count_d;
      end
   end

   // Head view freezes on the last shown command once the queue drains.
   always_comb begin
      if (cmd_valid) begin
         {cmd_ir, jdo} = head;
      end else begin
         {cmd_ir, jdo} = hold_q;
      end
   end

   assign fifo_level = count_q;

   // ---------------------------------------------------------------------------------------
   // Registered decode of popped commands and sticky overflow
   // ---------------------------------------------------------------------------------------
   logic [NumChan-1:0]  act_d, noact_d;
   logic [NumChan-1:0]  act_q, noact_q;
   logic [IR_WIDTH-1:0] head_ir;
   logic                overflow_q;

   assign head_ir = head[EntW-1:SR_WIDTH];

   always_comb begin
      act_d   = '0;
      noact_d = '0;
      if (pop) begin
         if (head[ACTION_BIT]) begin
            act_d[head_ir] = 1'b1;
         end else begin
            noact_d[head_ir] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         act_q      <= '0;
         noact_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         act_q   <= act_d;
         noact_q <= noact_d;
         if (drop) begin
            overflow_q <= 1'b1;
         end else if (clear_overflow) begin
            overflow_q <= 1'b0;
         end
      end
   end

   assign take_action    = act_q;
   assign take_no_action = noact_q;
   assign overflow       = overflow_q;

endmodule

// File: tb/tb_debug_cmd_sysclk_bridge.sv
// Self-checking bench: queue-based reference model compared on every falling edge, plus
// directed scenarios with literal expectations.
module tb_debug_cmd_sysclk_bridge;

   localparam int SR_W   = 38;
   localparam int IR_W   = 2;
   localparam int SYNC   = 2;
   localparam int DEPTH  = 4;
   localparam int ACTBIT = 35;

   typedef logic [IR_W+SR_W-1:0] ent_t;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [SR_W-1:0] sr = '0;
   logic [IR_W-1:0] ir_in = '0;
   logic            vs_udr = 1'b0;
   logic            vs_uir = 1'b0;
   logic            cmd_ready = 1'b0;
   logic            clear_overflow = 1'b0;
   logic            cmd_valid;
   logic [IR_W-1:0] cmd_ir;
   logic [SR_W-1:0] jdo;
   logic [3:0]      take_action, take_no_action;
   logic            ir_update, overflow;
   logic [2:0]      fifo_level;

   int checks = 0;
   int failures = 0;

   debug_cmd_sysclk_bridge #(
      .SR_WIDTH(SR_W), .IR_WIDTH(IR_W), .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH),
      .ACTION_BIT(ACTBIT)
   ) dut (
      .clk(clk), .reset(reset), .sr(sr), .ir_in(ir_in), .vs_udr(vs_udr), .vs_uir(vs_uir),
      .cmd_ready(cmd_ready), .clear_overflow(clear_overflow), .cmd_valid(cmd_valid),
      .cmd_ir(cmd_ir), .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
      .ir_update(ir_update), .overflow(overflow), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a rise seen at sample index e>=1 after release becomes a queued
   // command SYNC+1 edges later and an ir_update pulse SYNC edges later.
   ent_t       mq[$];
   int         push_at[$];
   int         uir_at[$];
   int         idx;
   logic       vprev_u, vprev_i;
   logic       m_ov;
   logic [3:0] m_act, m_noact;
   logic       m_irup;
   ent_t       m_held;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete(); push_at.delete(); uir_at.delete();
         idx = 0; vprev_u = 1'b0; vprev_i = 1'b0; m_ov = 1'b0;
         m_act = '0; m_noact = '0; m_irup = 1'b0; m_held = '0;
      end else begin
         automatic bit pop = (mq.size() != 0) && cmd_ready;
         automatic bit push = 1'b0;
         automatic bit drop = 1'b0;
         automatic ent_t h;
         if (mq.size() != 0) m_held = mq[0];
         m_act = '0; m_noact = '0;
         if (pop) begin
            h = mq[0];
            if (h[ACTBIT]) m_act[h[IR_W+SR_W-1:SR_W]] = 1'b1;
            else           m_noact[h[IR_W+SR_W-1:SR_W]] = 1'b1;
         end
         if (push_at.size() != 0 && push_at[0] == idx) begin
            push = 1'b1;
            void'(push_at.pop_front());
         end
         m_irup = 1'b0;
         if (uir_at.size() != 0 && uir_at[0] == idx) begin
            m_irup = 1'b1;
            void'(uir_at.pop_front());
         end
         if (push && mq.size() == DEPTH && !pop) drop = 1'b1;
         if (pop) void'(mq.pop_front());
         if (push && !drop) mq.push_back({ir_in, sr});
         if (drop) m_ov = 1'b1;
         else if (clear_overflow) m_ov = 1'b0;
         if (vs_udr && !vprev_u && idx >= 1) push_at.push_back(idx + SYNC + 1);
         if (vs_uir && !vprev_i && idx >= 1) uir_at.push_back(idx + SYNC);
         vprev_u = vs_udr;
         vprev_i = vs_uir;
         idx++;
      end
   end

   always @(negedge clk) begin
      automatic ent_t shown = (mq.size() != 0) ? mq[0] : m_held;
      chk("m_valid", cmd_valid, mq.size() != 0);
      chk("m_level", fifo_level, mq.size());
      chk("m_jdo", jdo, shown[SR_W-1:0]);
      chk("m_cmd_ir", cmd_ir, shown[IR_W+SR_W-1:SR_W]);
      chk("m_act", take_action, m_act);
      chk("m_noact", take_no_action, m_noact);
      chk("m_irupd", ir_update, m_irup);
      chk("m_ovf", overflow, m_ov);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic udr_pulse(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] d);
      ir_in = ir; sr = d; vs_udr = 1'b1;
      tick(4);
      vs_udr = 1'b0;
      tick(4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      chk("rst_valid", cmd_valid, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_act", {take_action, take_no_action}, 0);
      tick(4);

      // Action command, ir 2
      ir_in = 2; sr = 38'h08_1234_5678; cmd_ready = 1'b1; vs_udr = 1'b1;
      tick(3);
      chk("t1_latency_lo", cmd_valid, 0);
      tick(1);
      chk("t1_latency_hi", cmd_valid, 1);
      chk("t1_jdo", jdo, 38'h08_1234_5678);
      chk("t1_cmd_ir", cmd_ir, 2);
      vs_udr = 1'b0;
      tick(1);
      chk("t1_act", take_action, 4'b0100);
      chk("t1_noact", take_no_action, 4'b0000);
      tick(1);
      chk("t1_act_end", take_action, 4'b0000);
      chk("t1_jdo_hold", jdo, 38'h08_1234_5678);
      tick(4);

      // No-action command, ir 1
      ir_in = 1; sr = 38'h00_0000_00AB; vs_udr = 1'b1;
      tick(4);
      vs_udr = 1'b0;
      tick(1);
      chk("t2_noact", take_no_action, 4'b0010);
      chk("t2_act", take_action, 4'b0000);
      tick(1);
      chk("t2_noact_end", take_no_action, 4'b0000);
      tick(2);

      // IR update strobe
      vs_uir = 1'b1;
      tick(3);
      chk("uir_pulse", ir_update, 1);
      tick(1);
      chk("uir_end", ir_update, 0);
      chk("uir_level", fifo_level, 0);
      vs_uir = 1'b0;
      tick(4);

      // Overflow: five commands into a four-deep queue
      cmd_ready = 1'b0;
      for (int i = 1; i <= 5; i++) udr_pulse(0, SR_W'(i));
      chk("t3_level", fifo_level, 4);
      chk("t3_ovf", overflow, 1);
      for (int i = 1; i <= 4; i++) begin
         chk("t3_order", jdo, i);
         cmd_ready = 1'b1;
         tick(1);
         cmd_ready = 1'b0;
      end
      chk("t3_empty", cmd_valid, 0);
      chk("t3_ovf_sticky", overflow, 1);
      clear_overflow = 1'b1;
      tick(1);
      clear_overflow = 1'b0;
      chk("t3_ovf_clr", overflow, 0);

      // Push coincident with pop on a full queue
      for (int i = 0; i < 4; i++) udr_pulse(3, SR_W'(32'h10 + i));
      chk("t4_full", fifo_level, 4);
      ir_in = 0; sr = 38'h14; vs_udr = 1'b1;
      tick(3);
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
      vs_udr = 1'b0;
      chk("t4_ovf", overflow, 0);
      chk("t4_level", fifo_level, 4);
      for (int i = 1; i <= 4; i++) begin
         chk("t4_order", jdo, 32'h10 + i);
         cmd_ready = 1'b1;
         tick(1);
         cmd_ready = 1'b0;
      end
      tick(2);

      // Strobe held high across reset release
      reset = 1'b1; vs_udr = 1'b1; ir_in = 1; sr = 38'h2A;
      tick(2);
      reset = 1'b0;
      tick(10);
      chk("t5_no_cmd", cmd_valid, 0);
      chk("t5_level0", fifo_level, 0);
      vs_udr = 1'b0;
      tick(3);
      vs_udr = 1'b1;
      tick(4);
      vs_udr = 1'b0;
      tick(4);
      chk("t5_one_cmd", fifo_level, 1);

      // Async reset with queued commands and a live pulse
      for (int i = 0; i < 3; i++) udr_pulse(2, SR_W'(32'h30 + i));
      chk("t6_full", fifo_level, 4);
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
      chk("t6_pulse", take_no_action, 4'b0010);
      chk("t6_level3", fifo_level, 3);
      reset = 1'b1;
      #1;
      chk("t6_valid", cmd_valid, 0);
      chk("t6_level", fifo_level, 0);
      chk("t6_pulses", {take_action, take_no_action}, 0);
      chk("t6_jdo", jdo, 0);
      tick(2);
      reset = 1'b0;
      tick(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
